// File: rtl/wb_seq_pkg.sv
// wb_seq_pkg: state encoding and header field positions for the Wishbone command sequencer
package wb_seq_pkg;
  typedef enum logic [2:0] {HDR = 3'd0, DLO = 3'd1, DHI = 3'd2, BUS = 3'd3, RSP = 3'd4} state_t;
  localparam int WE_BIT  = 15;
  localparam int SEL_MSB = 14;
  localparam int SEL_LSB = 11;
  localparam int ADR_MSB = 5;
endpackage

// File: rtl/wb_cmd_sequencer.sv
// wb_cmd_sequencer: assembles 16-bit command words into single Wishbone classic transfers
module wb_cmd_sequencer
  import wb_seq_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_we_o,
  output logic [5:0]  m_wb_adr_o,
  output logic [3:0]  m_wb_sel_o,
  output logic [31:0] m_wb_dat_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i
);
  state_t st;
  logic [TO_W-1:0] cnt;
  logic xfer, expired;
  assign cmd_ready_o = (st == HDR) || (st == DLO) || (st == DHI);
  assign rsp_valid_o = st == RSP;
  assign xfer = cmd_valid_i && cmd_ready_o;
  assign expired = (TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT - 1));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st         <= HDR;
      cnt        <= '0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
      m_wb_cyc_o <= 1'b0;
      m_wb_stb_o <= 1'b0;
      m_wb_we_o  <= 1'b0;
      m_wb_adr_o <= '0;
      m_wb_sel_o <= '0;
      m_wb_dat_o <= '0;
    end else begin
      case (st)
        HDR: if (xfer) begin
          m_wb_we_o  <= cmd_data_i[WE_BIT];
          m_wb_sel_o <= cmd_data_i[SEL_MSB:SEL_LSB];
          m_wb_adr_o <= cmd_data_i[ADR_MSB:0];
          if (cmd_data_i[WE_BIT]) st <= DLO;
          else begin
            st         <= BUS;
            cnt        <= '0;
            m_wb_cyc_o <= 1'b1;
            m_wb_stb_o <= 1'b1;
          end
        end
        DLO: if (xfer) begin
          m_wb_dat_o[15:0] <= cmd_data_i;
          st               <= DHI;
        end
        DHI: if (xfer) begin
          m_wb_dat_o[31:16] <= cmd_data_i;
          st                <= BUS;
          cnt               <= '0;
          m_wb_cyc_o        <= 1'b1;
          m_wb_stb_o        <= 1'b1;
        end
        BUS: begin
          cnt <= cnt + 1'b1;
          // ack takes priority over a timeout landing on the same cycle
          if (m_wb_ack_i || expired) begin
            rsp_data_o <= (m_wb_ack_i && !m_wb_we_o) ? m_wb_dat_i : 32'd0;
            rsp_err_o  <= !m_wb_ack_i;
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            st         <= RSP;
          end
        end
        RSP: if (rsp_ready_i) st <= HDR;
        default: st <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// tb_wb_cmd_sequencer: table-driven and directed checks of the command sequencer with TIMEOUT=4
module tb_wb_cmd_sequencer;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_err, ack = 0;
  logic cyc, stb, we;
  logic [15:0] cmd_data = 0;
  logic [31:0] rsp_data, wdat, rdat = 0;
  logic [5:0] adr;
  logic [3:0] sel;
  int n_cmp = 0, n_bad = 0;

  wb_cmd_sequencer #(.TIMEOUT(4), .TO_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_data_i(cmd_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .m_wb_cyc_o(cyc), .m_wb_stb_o(stb),
    .m_wb_we_o(we), .m_wb_adr_o(adr), .m_wb_sel_o(sel), .m_wb_dat_o(wdat),
    .m_wb_dat_i(rdat), .m_wb_ack_i(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hdr, dlo, dhi;
    int          wait_n;
    logic [31:0] rdata;
    logic        exp_we;
    logic [5:0]  exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdat, exp_rsp;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t v[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    int k;
    @(negedge clk);
    cmd_valid = 1;
    cmd_data = w;
    for (k = 0; k < 30 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic run_vec(input vec_t t, input int id);
    int n;
    rdat = t.rdata;
    send_word(t.hdr);
    if (t.exp_we) begin
      send_word(t.dlo);
      send_word(t.dhi);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cyc) break;
      if (i == 0) begin
        chk($sformatf("v%0d_stb", id), 32'(stb), 32'd1);
        chk($sformatf("v%0d_we", id), 32'(we), 32'(t.exp_we));
        chk($sformatf("v%0d_adr", id), 32'(adr), 32'(t.exp_adr));
        chk($sformatf("v%0d_sel", id), 32'(sel), 32'(t.exp_sel));
        if (t.exp_we) chk($sformatf("v%0d_wdat", id), wdat, t.exp_wdat);
        chk($sformatf("v%0d_ready_bus", id), 32'(cmd_ready), 32'd0);
      end
      ack = (i == t.wait_n);
      n++;
      @(posedge clk);
      #1 ack = 0;
    end
    chk($sformatf("v%0d_cycles", id), n, t.exp_cycles);
    chk($sformatf("v%0d_rsp_valid", id), 32'(rsp_valid), 32'd1);
    chk($sformatf("v%0d_rsp_data", id), rsp_data, t.exp_rsp);
    chk($sformatf("v%0d_rsp_err", id), 32'(rsp_err), 32'(t.exp_err));
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk($sformatf("v%0d_back_hdr", id), 32'({cmd_ready, rsp_valid}), 32'b10);
  endtask

  initial begin
    logic [31:0] held;
    v[0] = '{16'hF803, 16'h5678, 16'h1234, 2, 32'hAAAA5555, 1, 6'd3, 4'hF, 32'h12345678, 32'h0, 0, 3};
    v[1] = '{16'h780A, 16'h0, 16'h0, 0, 32'hCAFEF00D, 0, 6'd10, 4'hF, 32'h0, 32'hCAFEF00D, 0, 1};
    v[2] = '{16'h7805, 16'h0, 16'h0, -1, 32'hDEADBEEF, 0, 6'd5, 4'hF, 32'h0, 32'h0, 1, 4};
    v[3] = '{16'h0821, 16'h0, 16'h0, 3, 32'h11223344, 0, 6'h21, 4'h1, 32'h0, 32'h11223344, 0, 4};
    v[4] = '{16'hAFEA, 16'hBEEF, 16'hDEAD, 0, 32'hFFFFFFFF, 1, 6'h2A, 4'h5, 32'hDEADBEEF, 32'h0, 0, 1};

    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outs", {rsp_valid, rsp_err, cyc, stb, we, 27'd0}, 32'd0);
    chk("rst_data", rsp_data ^ wdat, 32'd0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 5; i++) run_vec(v[i], i);

    // ack held high while idle must be ignored, then a zero-wait read completes
    rdat = 32'h0BADCAFE;
    ack = 1;
    repeat (3) @(negedge clk);
    chk("idle_ack_ignored", 32'({cmd_ready, rsp_valid, cyc}), 32'b100);
    send_word(16'h780A);
    @(negedge clk);
    chk("lat_bus", 32'({cyc, rsp_valid}), 32'b10);
    @(negedge clk);
    chk("lat_rsp", 32'({cyc, rsp_valid}), 32'b01);
    chk("lat_data", rsp_data, 32'h0BADCAFE);
    ack = 0;
    held = rsp_data;
    cmd_valid = 1;
    cmd_data = 16'h7807;
    rdat = 32'h55555555;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'({cmd_ready, rsp_valid}), 32'b01);
      chk("bp_data", rsp_data, held);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk("bp_release", 32'({cmd_ready, rsp_valid, cyc}), 32'b100);
    @(posedge clk);
    #1 cmd_valid = 0;
    @(negedge clk);
    chk("bp_next_bus", 32'({cyc, adr}), {25'd0, 1'b1, 6'd7});
    ack = 1;
    @(posedge clk);
    #1 ack = 0;
    @(negedge clk);
    chk("bp_next_rsp", rsp_data, 32'h55555555);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;

    // asynchronous reset in the second BUS cycle
    send_word(16'h7805);
    @(negedge clk);
    chk("mid_bus1", 32'(cyc), 32'd1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_bus", 32'({cyc, stb, rsp_valid}), 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 0;
    run_vec(v[1], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
